// File: rtl/rtl_rom_arbiter_pkg.sv
// Shared definitions for the two-port ROM arbiter: state encoding and sizing defaults.
package rtl_rom_arbiter_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_BURST  = 4;
    localparam int LEN_W      = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_READ  = 2'd2
    } state_t;

endpackage

// File: rtl/rtl_rom_arbiter_rr_pointer.sv
// Two-requester round-robin selector; remembers which port won last.
module rr_pointer (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic fetch_req,
    input  logic data_req,
    output logic pick_fetch,
    output logic pick_data
);

    logic last_data;

    always_comb begin
        pick_fetch = 1'b0;
        pick_data  = 1'b0;
        if (arb_en) begin
            if (fetch_req && data_req) begin
                pick_fetch = last_data;
                pick_data  = !last_data;
            end else begin
                pick_fetch = fetch_req;
                pick_data  = data_req;
            end
        end
    end

    // Reset marks data as last winner so the fetch port is favoured first.
    always_ff @(posedge clk) begin
        if (!rst)
            last_data <= 1'b1;
        else if (pick_fetch)
            last_data <= 1'b0;
        else if (pick_data)
            last_data <= 1'b1;
    end

endmodule

// File: rtl/rtl_rom_arbiter.sv
// Arbitrates a bursting fetch port and a single-beat data port onto one combinational ROM.
module rtl_rom_arbiter
    import rtl_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_adrs,
    input  logic [LEN_W-1:0]  i_len,
    output logic              i_gnt,
    output logic              i_valid,
    output logic              i_last,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_adrs,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] rom_adrs,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              busy
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] d_base;
    logic [LEN_W-1:0]  blen;
    logic [LEN_W-1:0]  beat;
    logic              pick_fetch, pick_data;
    logic              final_beat;

    rr_pointer u_rr (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (state == IDLE),
        .fetch_req  (i_req),
        .data_req   (d_req),
        .pick_fetch (pick_fetch),
        .pick_data  (pick_data)
    );

    assign final_beat = (beat == blen);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_fetch)
                    state_nx = I_BURST;
                else if (pick_data)
                    state_nx = D_READ;
            end
            I_BURST: if (final_beat) state_nx = IDLE;
            D_READ:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Address sum deliberately truncates to ADDR_W so bursts wrap at the top of the ROM.
    always_comb begin
        rom_adrs = '0;
        case (state)
            I_BURST: rom_adrs = base + ADDR_W'(beat);
            D_READ:  rom_adrs = d_base;
            default: rom_adrs = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            d_base  <= '0;
            blen    <= '0;
            beat    <= '0;
            i_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            i_valid <= 1'b0;
            i_last  <= 1'b0;
            d_valid <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state   <= state_nx;
            i_gnt   <= pick_fetch;
            d_gnt   <= pick_data;
            i_valid <= (state == I_BURST);
            i_last  <= (state == I_BURST) && final_beat;
            d_valid <= (state == D_READ);
            if (pick_fetch) begin
                base <= i_adrs;
                blen <= i_len;
                beat <= '0;
            end else if (state == I_BURST) begin
                beat <= beat + 1'b1;
            end
            if (pick_data)
                d_base <= d_adrs;
            if (state == I_BURST)
                i_rdata <= rom_dout;
            if (state == D_READ)
                d_rdata <= rom_dout;
        end
    end

endmodule

// File: tb/tb_rtl_rom_arbiter.sv
// Randomized and directed bench for rtl_rom_arbiter against a transaction-timeline model.
module tb_rtl_rom_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req;
    logic [AW-1:0] i_adrs, d_adrs;
    logic [1:0]    i_len;
    logic          i_gnt, i_valid, i_last, d_gnt, d_valid, busy;
    logic [DW-1:0] i_rdata, d_rdata, rom_dout;
    logic [AW-1:0] rom_adrs;

    logic [DW-1:0] rom [0:511];
    assign rom_dout = rom[rom_adrs];

    always #5 clk = ~clk;

    rtl_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_adrs(i_adrs), .i_len(i_len),
        .i_gnt(i_gnt), .i_valid(i_valid), .i_last(i_last), .i_rdata(i_rdata),
        .d_req(d_req), .d_adrs(d_adrs),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .rom_adrs(rom_adrs), .rom_dout(rom_dout), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Model state: which port won last, and the held read-data values.
    bit            mdl_last_data;
    logic [DW-1:0] mdl_ird, mdl_drd;

    // Expected per-cycle outputs; e_ctl = {i_gnt,d_gnt,i_valid,i_last,d_valid,busy}
    logic [5:0]    e_ctl [0:31];
    logic [AW-1:0] e_ra  [0:31];
    logic [DW-1:0] e_id  [0:31];
    logic [DW-1:0] e_dd  [0:31];

    // One transaction group starting from IDLE in cycle 0; d_req may join at d_start.
    task automatic test_transaction(input bit do_i, input bit do_d, input int d_start,
                                    input logic [AW-1:0] ia, input logic [1:0] il,
                                    input logic [AW-1:0] da, input string tag);
        int n, gi, gd, tot, endc;
        bit fetch_first;
        logic [AW-1:0] a;
        logic [5:0] obs;
        n  = int'(il) + 1;
        gi = -1;
        gd = -1;
        if (do_i && do_d && d_start == 0) fetch_first = !mdl_last_data ? 1'b0 : 1'b1;
        else fetch_first = do_i;
        if (fetch_first) begin
            gi = 1;
            if (do_d) gd = gi + n + 1;
        end else begin
            gd = 1;
            if (do_i) gi = gd + 2;
        end
        if (do_i && do_d) mdl_last_data = fetch_first;
        else mdl_last_data = do_d;
        for (int c = 0; c < 32; c++) begin
            e_ctl[c] = '0; e_ra[c] = '0; e_id[c] = '0; e_dd[c] = '0;
        end
        endc = 0;
        if (gi >= 0) begin
            e_ctl[gi][5] = 1'b1;
            for (int k = 0; k < n; k++) begin
                a = ia + AW'(k);
                e_ctl[gi+k][0]   = 1'b1;
                e_ra[gi+k]       = a;
                e_ctl[gi+k+1][3] = 1'b1;
                e_id[gi+k+1]     = rom[a];
            end
            e_ctl[gi+n][2] = 1'b1;
            endc = gi + n;
        end
        if (gd >= 0) begin
            e_ctl[gd][4]   = 1'b1;
            e_ctl[gd][0]   = 1'b1;
            e_ra[gd]       = da;
            e_ctl[gd+1][1] = 1'b1;
            e_dd[gd+1]     = rom[da];
            if (gd + 1 > endc) endc = gd + 1;
        end
        tot = endc + 2;
        for (int c = 0; c < tot; c++) begin
            i_req  = do_i && (c <= gi);
            d_req  = do_d && (c >= d_start) && (c <= gd);
            i_adrs = ia;
            i_len  = il;
            d_adrs = da;
            if (e_ctl[c][3]) mdl_ird = e_id[c];
            if (e_ctl[c][1]) mdl_drd = e_dd[c];
            @(negedge clk);
            obs = {i_gnt, d_gnt, i_valid, i_last, d_valid, busy};
            checks++;
            if (obs !== e_ctl[c]) begin
                errors++;
                $display("FAIL %s c%0d ctl{ig,dg,iv,il,dv,busy} got %b exp %b", tag, c, obs, e_ctl[c]);
            end
            checks++;
            if (rom_adrs !== e_ra[c]) begin
                errors++;
                $display("FAIL %s c%0d rom_adrs got %h exp %h", tag, c, rom_adrs, e_ra[c]);
            end
            checks++;
            if (i_rdata !== mdl_ird) begin
                errors++;
                $display("FAIL %s c%0d i_rdata got %h exp %h", tag, c, i_rdata, mdl_ird);
            end
            checks++;
            if (d_rdata !== mdl_drd) begin
                errors++;
                $display("FAIL %s c%0d d_rdata got %h exp %h", tag, c, d_rdata, mdl_drd);
            end
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst    = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_adrs = 9'h055;
        i_len  = 2'd2;
        d_adrs = 9'h009;
        repeat (3) begin
            @(negedge clk);
            obs = {i_gnt, d_gnt, i_valid, i_last, d_valid, busy};
            checks++;
            if (obs !== 6'b0 || rom_adrs !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
                errors++;
                $display("FAIL reset ctl=%b rom_adrs=%h i_rdata=%h d_rdata=%h exp all zero",
                         obs, rom_adrs, i_rdata, d_rdata);
            end
        end
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        rst   = 1'b1;
        mdl_last_data = 1'b1;
        mdl_ird = '0;
        mdl_drd = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_fetch();
        test_transaction(1'b1, 1'b0, 0, 9'h000, 2'd3, 9'h000, "single_fetch");
    endtask

    task automatic test_wrap();
        test_transaction(1'b1, 1'b0, 0, 9'h1FE, 2'd3, 9'h000, "wrap");
    endtask

    task automatic test_data_read();
        test_transaction(1'b0, 1'b1, 0, 9'h000, 2'd0, 9'h009, "data_read");
    endtask

    task automatic test_round_robin();
        test_transaction(1'b1, 1'b1, 0, 9'h010, 2'd1, 9'h020, "rr_fetch_first");
        test_transaction(1'b1, 1'b0, 0, 9'h030, 2'd0, 9'h000, "rr_fetch_solo");
        test_transaction(1'b1, 1'b1, 0, 9'h040, 2'd2, 9'h050, "rr_data_wins");
    endtask

    task automatic test_mid_burst_data();
        test_transaction(1'b1, 1'b1, 2, 9'h100, 2'd3, 9'h0AA, "mid_burst_data");
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] ia;
        logic [5:0] obs;
        ia     = AW'($urandom);
        i_req  = 1'b1;
        i_adrs = ia;
        i_len  = 2'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_req = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checks++;
        if (i_valid !== 1'b1 || i_rdata !== rom[ia]) begin
            errors++;
            $display("FAIL rst_mid beat0 i_valid=%b i_rdata=%h exp 1 %h", i_valid, i_rdata, rom[ia]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {i_gnt, d_gnt, i_valid, i_last, d_valid, busy};
            checks++;
            if (obs !== 6'b0 || rom_adrs !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
                errors++;
                $display("FAIL rst_mid c%0d ctl=%b rom_adrs=%h i_rdata=%h d_rdata=%h exp all zero",
                         c, obs, rom_adrs, i_rdata, d_rdata);
            end
            @(posedge clk); #1;
        end
        mdl_last_data = 1'b1;
        mdl_ird = '0;
        mdl_drd = '0;
        test_transaction(1'b1, 1'b0, 0, 9'h0F0, 2'd3, 9'h000, "rst_mid_fresh");
    endtask

    task automatic test_random();
        bit do_i, do_d;
        int ds;
        logic [1:0] il;
        for (int t = 0; t < 30; t++) begin
            do_i = $urandom_range(0, 1);
            do_d = do_i ? bit'($urandom_range(0, 1)) : 1'b1;
            il   = 2'($urandom);
            ds   = do_i ? $urandom_range(0, int'(il) + 1) : 0;
            test_transaction(do_i, do_d, ds, AW'($urandom), il, AW'($urandom), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = $urandom;
        rom[0] = 32'h3c011001;
        rom[1] = 32'h34300000;
        rom[2] = 32'h24020001;
        rom[3] = 32'h2404000d;
        rom[9] = 32'h00108820;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_adrs = '0; i_len = '0; d_adrs = '0;
        mdl_last_data = 1'b1; mdl_ird = '0; mdl_drd = '0;
        test_reset();
        test_single_fetch();
        test_wrap();
        test_data_read();
        test_round_robin();
        test_mid_burst_data();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtl_rom_arbiter.md
RTL_ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, 9, ROM word-address width.
REQ-002 Parameter DATA_W, 32, ROM word width.
REQ-003 Port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-low (rst=0 at a rising edge resets).
REQ-005 Port i_req  in  1  fetch-port request, level.
REQ-006 Port i_adrs  in  ADDR_W  fetch burst start address.
REQ-007 Port i_len  in  2  fetch burst length minus one (1..4 beats).
REQ-008 Port i_gnt  out  1  one-cycle fetch grant pulse.
REQ-009 Port i_valid  out  1  fetch data-beat valid.
REQ-010 Port i_last  out  1  final fetch beat, qualified by i_valid.
REQ-011 Port i_rdata  out  DATA_W  fetch read data.
REQ-012 Port d_req  in  1  data-port request, level, single beat.
REQ-013 Port d_adrs  in  ADDR_W  data-port address.
REQ-014 Port d_gnt  out  1  one-cycle data grant pulse.
REQ-015 Port d_valid  out  1  data-port read valid.
REQ-016 Port d_rdata  out  DATA_W  data-port read data.
REQ-017 Port rom_adrs  out  ADDR_W  address to combinational ROM.
REQ-018 Port rom_dout  in  DATA_W  ROM read word, same cycle as rom_adrs.
REQ-019 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, I_BURST, D_READ; arbitration occurs only in IDLE.
REQ-021 IDLE, only i_req: latch i_adrs/i_len, go to I_BURST; only d_req: latch d_adrs, go to D_READ; neither: stay.
REQ-022 IDLE, both requesting: grant the port not granted last (round-robin pointer); pointer updates on every grant.
REQ-023 Grant pulse (i_gnt/d_gnt) is registered, high exactly in the first cycle of the granted state.
REQ-024 Requester holds req/adrs/len stable until its gnt and deasserts req in the cycle after gnt; req high in IDLE again is a new request.
REQ-025 I_BURST: beat counter 0..i_len; rom_adrs = base + beat, modulo 2^ADDR_W (0x1FF+1 wraps to 0x000).
REQ-026 Each beat: rom_dout registered into i_rdata; i_valid high next cycle; i_last high with final beat.
REQ-027 I_BURST is non-preemptive; d_req during a burst waits; after final beat FSM returns to IDLE (one-cycle bubble before next grant).
REQ-028 D_READ lasts one cycle; rom_dout registered into d_rdata, d_valid high next cycle; then IDLE.
REQ-029 Latency: request in IDLE cycle T -> gnt in T+1 -> first valid in T+2; N-beat burst gives valids T+2..T+N+1.
REQ-030 rom_adrs = 0 in IDLE; i_valid and d_valid never high in the same cycle.
REQ-031 i_rdata/d_rdata hold last value while their valid is low.

Reset
REQ-032 rst=0: state IDLE, pointer favours fetch port next, beat counter 0.
REQ-033 Reset values: i_gnt, d_gnt, i_valid, d_valid, i_last, busy = 0; i_rdata, d_rdata, rom_adrs = 0.
REQ-034 Reset mid-burst aborts it: no further valids, pending data discarded; requester must re-request.

Structure
REQ-035 Shared package: FSM state encoding, ADDR_W/DATA_W defaults, MAX_BURST = 4.
REQ-036 One sub-module, rr_pointer: two-requester round-robin grant selection with last-grant register.

Verification
REQ-037 Single fetch i_adrs=0x000, i_len=3 -> i_gnt at T+1; i_valid T+2..T+5 with ROM words 0..3 (0x3c011001, 0x34300000, 0x24020001, 0x2404000d); i_last at T+5.
REQ-038 Simultaneous i_req/d_req after reset -> fetch granted first; d_req held -> d_gnt one cycle after burst ends; next simultaneous pair -> data port wins.
REQ-039 Wrap: i_adrs=0x1FE, i_len=3 -> rom_adrs 0x1FE, 0x1FF, 0x000, 0x001; beats 3-4 return 0x3c011001, 0x34300000.
REQ-040 d_req d_adrs=0x009 alone -> d_gnt T+1, d_valid T+2, d_rdata=0x00108820; i_valid stays 0.
REQ-041 rst=0 during beat 2 of 4-beat burst -> next cycle all outputs at reset values, no i_last; fresh request completes normally.
REQ-042 d_req asserted mid-burst -> no d_gnt until busy drops; i_valid and d_valid never coincide.
